// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: command and status bundle between a controller and the
// channel scanner.
//   master : drives start/stop/mode/mask/dwell, observes the scanner outputs
//   slave  : the scanner itself
// Handshake: there is no valid/ready pair. start and stop are level commands
// that are sampled on every rising clock edge; step and done are single-cycle
// pulses that the master must sample on the cycle they are high.
// scan_st mirrors the scanner state register (0 = IDLE, 1 = SCAN) for
// debug and checker binding.
interface scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [15:0]        mask;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         sel;
  logic               sel_en;
  logic               step;
  logic               busy;
  logic               done;
  logic               scan_st;

  modport master (
    output start, stop, mode, mask, dwell,
    input  sel, sel_en, step, busy, done, scan_st
  );

  modport slave (
    input  start, stop, mode, mask, dwell,
    output sel, sel_en, step, busy, done, scan_st
  );
endinterface

// File: rtl/scan_sequencer.sv
// scan_sequencer: walks the channels whose mask bit is set in ascending
// order and holds each for dwell+1 cycles, driving the index/enable of a
// 4-to-16 one-hot decoder. Single-pass or continuous (wrap) operation.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - scan_sequencer_if.slave (commands in, registered status out)
// Every output is a flop, so sel and sel_en change on the same edge and the
// decoder never sees an intermediate code.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [3:0]         sel_q, sel_n;
  logic               en_q, en_n;
  logic               step_q, step_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n;

  logic [3:0]         low_idx;
  logic [3:0]         next_idx;
  logic               next_found;
  logic               mask_any;

  // Priority search over the live mask. Scanning from the top down and
  // overwriting means the last hit is the lowest qualifying bit.
  always_comb begin
    low_idx    = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (bus.mask[i]) begin
        low_idx = 4'(i);
      end
      if (bus.mask[i] && (4'(i) > sel_q)) begin
        next_idx   = 4'(i);
        next_found = 1'b1;
      end
    end
  end

  assign mask_any = |bus.mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      en_q    <= en_n;
      step_q  <= step_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      cnt_q   <= cnt_n;
    end
  end

  // The counter runs dwell..0 on each channel, giving dwell+1 cycles of hold.
  // stop is tested before the counter so it overrides an advance that is due
  // in the same cycle.
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    en_n    = en_q;
    step_n  = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        en_n   = 1'b0;
        busy_n = 1'b0;
        if (bus.start && !bus.stop) begin
          if (mask_any) begin
            state_n = SCAN;
            sel_n   = low_idx;
            cnt_n   = bus.dwell;
            en_n    = 1'b1;
            busy_n  = 1'b1;
            step_n  = 1'b1;
          end else begin
            // Empty pass: report completion without ever going busy.
            done_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_n = IDLE;
          en_n    = 1'b0;
          busy_n  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - 1'b1;
        end else if (next_found) begin
          sel_n  = next_idx;
          cnt_n  = bus.dwell;
          step_n = 1'b1;
        end else if (bus.mode && mask_any) begin
          // Wrap; may re-select the same channel, which still gets a step.
          sel_n  = low_idx;
          cnt_n  = bus.dwell;
          step_n = 1'b1;
        end else begin
          state_n = IDLE;
          en_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.sel     = sel_q;
  assign bus.sel_en  = en_q;
  assign bus.step    = step_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.scan_st = (state_q == SCAN);

endmodule
